// File: rtl/floatingpoint.sv
// Shared floating-point definitions: operand classes, exception flags and
// helpers used by the add/sub pipeline and its normaliser.
package floatingpoint;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Subnormals (exponent zero) are treated as zero throughout.
  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic man_zero);
    if (exp_zero) return ZERO;
    if (exp_ones) return man_zero ? INF : NAN;
    return NORMAL;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the normalise stage; count equals W when value is zero.
module fp_lzc #(
  parameter  int W  = 27,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
    all_zero = (value == '0);
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-style adder/subtractor: S1 unpack/compare/align,
// S2 significand add/sub, S3 normalise/round-to-nearest-even/pack.
module fp_addsub_pipe
  import floatingpoint::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] OpA,
  input  logic [W-1:0] OpB,
  input  logic         Sub,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [W-1:0] Result,
  output logic [3:0]   Flags
);

  localparam int SW  = MAN_W + 4;          // hidden + mantissa + guard/round/sticky
  localparam int LZW = $clog2(SW + 1);
  localparam int XW  = EXP_W + 2;          // two's-complement working exponent
  localparam logic [W-1:0] CANON_NAN = W'(canon_nan(EXP_W, MAN_W));

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    fp_class_e        cls;
  } fp_operand_t;

  function automatic fp_operand_t unpack(input logic [W-1:0] v, input logic flip);
    fp_operand_t o;
    o.sign = v[W-1] ^ flip;
    o.exp  = v[W-2 -: EXP_W];
    o.cls  = classify(o.exp == '0, &o.exp, v[MAN_W-1:0] == '0);
    o.sig  = (o.cls == NORMAL) ? {1'b1, v[MAN_W-1:0]} : '0;
    return o;
  endfunction

  // Valid/ready: a word moves across an interface on a rising edge where both
  // valid and ready are high; a stage register loads when empty or draining.
  logic v1, v2, v3, ld2, ld3;
  assign ld3      = !v3 || OutReady;
  assign ld2      = !v2 || ld3;
  assign InReady  = !v1 || ld2;
  assign OutValid = v3;

  // ---------------- S1: unpack, order by magnitude, align B ----------------
  fp_operand_t      a, b;
  logic [EXP_W-1:0] ediff;
  logic [SW-1:0]    b_ext, b_sh, lost_mask, b_aln;
  logic             sp_hit;
  logic [W-1:0]     sp_res;
  fp_flags_t        sp_flags;

  always_comb begin
    if (OpB[W-2:0] > OpA[W-2:0]) begin
      a = unpack(OpB, Sub);
      b = unpack(OpA, 1'b0);
    end else begin
      a = unpack(OpA, 1'b0);
      b = unpack(OpB, Sub);
    end
    ediff     = a.exp - b.exp;
    b_ext     = {b.sig, 3'b000};
    b_sh      = '0;
    lost_mask = '0;
    if (int'(ediff) >= MAN_W + 3) begin
      b_aln = {{(SW-1){1'b0}}, |b.sig};
    end else begin
      b_sh      = b_ext >> ediff;
      lost_mask = ~({SW{1'b1}} << ediff);
      b_aln     = {b_sh[SW-1:1], b_sh[0] | (|(b_ext & lost_mask))};
    end
    // Infinity always sorts into A, so only A needs inspecting for inf+finite.
    sp_hit   = 1'b1;
    sp_res   = CANON_NAN;
    sp_flags = '0;
    if (a.cls == NAN || b.cls == NAN) begin
      sp_res = CANON_NAN;
    end else if (a.cls == INF && b.cls == INF && a.sign != b.sign) begin
      sp_flags.invalid = 1'b1;
    end else if (a.cls == INF) begin
      sp_res = {a.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic             s1_sign, s1_sub, s1_zsign, s1_sp_hit;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_siga, s1_sigb;
  logic [W-1:0]     s1_sp_res;
  fp_flags_t        s1_sp_flags;

  // ---------------- S2: significand add / subtract ----------------
  logic             s2_sign, s2_zsign, s2_sp_hit;
  logic [EXP_W-1:0] s2_exp;
  logic [SW:0]      s2_sum;
  logic [W-1:0]     s2_sp_res;
  fp_flags_t        s2_sp_flags;

  always_ff @(posedge Clock) begin
    if (InReady && InValid) begin
      s1_sign     <= a.sign;
      s1_sub      <= a.sign ^ b.sign;
      s1_zsign    <= a.sign & b.sign;   // zero result is negative only for (-0)+(-0)
      s1_exp      <= a.exp;
      s1_siga     <= {a.sig, 3'b000};
      s1_sigb     <= b_aln;
      s1_sp_hit   <= sp_hit;
      s1_sp_res   <= sp_res;
      s1_sp_flags <= sp_flags;
    end
    if (ld2 && v1) begin
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_sub ? ({1'b0, s1_siga} - {1'b0, s1_sigb})
                            : ({1'b0, s1_siga} + {1'b0, s1_sigb});
      s2_sp_hit   <= s1_sp_hit;
      s2_sp_res   <= s1_sp_res;
      s2_sp_flags <= s1_sp_flags;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0] lz;
  logic           lz_zero;

  fp_lzc #(.W(SW)) u_lzc (
    .value    (s2_sum[SW-1:0]),
    .count    (lz),
    .all_zero (lz_zero)
  );

  logic [SW-1:0]    norm;
  logic [XW-1:0]    exp_n, exp_f;
  logic [MAN_W+1:0] hr;
  logic             round_up;
  logic [W-1:0]     res_d;
  fp_flags_t        flags_d;

  always_comb begin
    if (s2_sum[SW]) begin
      norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      exp_n = {2'b00, s2_exp} + XW'(1);
    end else begin
      norm  = s2_sum[SW-1:0] << lz;
      exp_n = {2'b00, s2_exp} - XW'(lz);
    end
    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    hr       = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    // hr top bits are 01 normally and 10 when rounding carried out of the mantissa.
    exp_f    = exp_n + {{(XW-2){1'b0}}, hr[MAN_W+1:MAN_W]} - XW'(1);
    res_d    = {s2_sign, exp_f[EXP_W-1:0], hr[MAN_W-1:0]};
    flags_d  = '0;
    flags_d.inexact = |norm[2:0];
    if (s2_sp_hit) begin
      res_d   = s2_sp_res;
      flags_d = s2_sp_flags;
    end else if (!s2_sum[SW] && lz_zero) begin
      res_d   = {s2_zsign, {(W-1){1'b0}}};
      flags_d = '0;
    end else if (exp_f[XW-1] || exp_f == '0) begin
      res_d             = {s2_sign, {(W-1){1'b0}}};
      flags_d.underflow = 1'b1;
      flags_d.inexact   = 1'b1;
    end else if (exp_f >= {2'b00, {EXP_W{1'b1}}}) begin
      res_d            = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d.overflow = 1'b1;
      flags_d.inexact  = 1'b1;
    end
  end

  logic [W-1:0] res_q;
  fp_flags_t    flags_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (InReady) v1 <= InValid;
      if (ld2)     v2 <= v1;
      if (ld3)     v3 <= v2;
      if (ld3 && v2) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign Result                = res_q;
  assign Flags[FLAG_INVALID]   = flags_q.invalid;
  assign Flags[FLAG_OVERFLOW]  = flags_q.overflow;
  assign Flags[FLAG_UNDERFLOW] = flags_q.underflow;
  assign Flags[FLAG_INEXACT]   = flags_q.inexact;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision vectors, stall/hold,
// mid-stream reset, and a double-precision build.
module tb_fp_addsub_pipe;

  logic        Clock = 1'b0;
  logic        Reset, InValid, InReady, Sub, OutValid, OutReady;
  logic [31:0] OpA, OpB, Result;
  logic [3:0]  Flags;

  logic        d_in_valid, d_in_ready, d_sub, d_out_valid, d_out_ready;
  logic [63:0] d_a, d_b, d_result;
  logic [3:0]  d_flags;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] exp_q[$];
  string       tag_q[$];
  logic [35:0] held;
  logic        held_valid = 1'b0;

  fp_addsub_pipe dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .OpA(OpA), .OpB(OpB), .Sub(Sub), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Flags(Flags)
  );

  fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut_dp (
    .Clock(Clock), .Reset(Reset), .InValid(d_in_valid), .InReady(d_in_ready),
    .OpA(d_a), .OpB(d_b), .Sub(d_sub), .OutValid(d_out_valid), .OutReady(d_out_ready),
    .Result(d_result), .Flags(d_flags)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / output monitor ----------------
  always @(negedge Clock) begin
    if (Reset) begin
      held_valid = 1'b0;
    end else if (OutValid) begin
      if (held_valid) check("hold_stable", {28'd0, Flags, Result}, {28'd0, held});
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(OutValid), 64'd0);
        held_valid = 1'b0;
      end else if (OutReady) begin
        check(tag_q.pop_front(), {28'd0, Flags, Result}, {28'd0, exp_q.pop_front()});
        held_valid = 1'b0;
      end else begin
        held       = {Flags, Result};
        held_valid = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    InValid = 1'b1;
    OpA     = a;
    OpB     = b;
    Sub     = s;
    @(negedge Clock);
    while (!InReady && n < 20) begin
      n++;
      @(negedge Clock);
    end
    if (!InReady) check({tag, "_accept"}, 64'(InReady), 64'd1);
    @(posedge Clock);
    #1;
    exp_q.push_back({ef, er});
    tag_q.push_back(tag);
  endtask

  task automatic idle();
    InValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge Clock);
      n++;
    end
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1; InValid = 1'b1; OpA = 32'h3F800000; OpB = 32'h3F800000; Sub = 1'b0;
    OutReady = 1'b1;
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_out_ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    InValid = 1'b0;
    @(negedge Clock);
    check("reset_outvalid", 64'(OutValid), 64'd0);
    check("reset_inready", 64'(InReady), 64'd1);
    check("reset_result", 64'(Result), 64'd0);
    check("reset_flags", 64'(Flags), 64'd0);

    // latency: OutValid rises exactly three cycles after acceptance
    @(posedge Clock); #1;
    send("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    idle();
    @(negedge Clock); check("latency_c1", 64'(OutValid), 64'd0);
    @(negedge Clock); check("latency_c2", 64'(OutValid), 64'd0);
    @(negedge Clock); check("latency_c3", 64'(OutValid), 64'd1);
    drain("latency");

    // directed vectors, issued back to back
    @(posedge Clock); #1;
    send("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    send("tie_even",       32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    send("tie_odd",        32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    send("overflow",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    send("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    send("neg0_plus_neg0", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    send("neg0_minus_neg0",32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'b0000);
    send("round_carry",    32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);
    send("exact_carry",    32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 4'b0000);
    idle();
    drain("directed");

    // stream of 8 with a downstream stall
    @(posedge Clock); #1;
    OutReady = 1'b0;
    send("s_three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
    send("s_one_minus_two",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    send("s_nan",             32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    idle();
    @(negedge Clock);
    check("stall_inready_low", 64'(InReady), 64'd0);
    check("stall_outvalid", 64'(OutValid), 64'd1);
    repeat (3) @(negedge Clock);
    check("stall_inready_still_low", 64'(InReady), 64'd0);
    @(posedge Clock); #1;
    OutReady = 1'b1;
    send("s_neg_inf",         32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    send("s_underflow",       32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
    send("s_subnormal_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    send("s_round_carry",     32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);
    send("s_far_sticky",      32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001);
    idle();
    drain("stream");

    // reset with operations in flight
    @(posedge Clock); #1;
    send("r_a", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    send("r_b", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);
    send("r_c", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
    Reset = 1'b1;
    exp_q.delete();
    tag_q.delete();
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    idle();
    @(negedge Clock);
    check("midreset_outvalid", 64'(OutValid), 64'd0);
    check("midreset_inready", 64'(InReady), 64'd1);
    check("midreset_result", 64'(Result), 64'd0);
    check("midreset_flags", 64'(Flags), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check("no_stale_output", 64'(OutValid), 64'd0);
    end

    // double-precision build: 1.0 + 2.0
    @(posedge Clock); #1;
    d_in_valid = 1'b1;
    d_a = 64'h3FF0000000000000;
    d_b = 64'h4000000000000000;
    d_sub = 1'b0;
    @(negedge Clock);
    check("dp_inready", 64'(d_in_ready), 64'd1);
    @(posedge Clock); #1;
    d_in_valid = 1'b0;
    begin
      int n = 0;
      @(negedge Clock);
      while (!d_out_valid && n < 10) begin
        n++;
        @(negedge Clock);
      end
    end
    check("dp_outvalid", 64'(d_out_valid), 64'd1);
    check("dp_result", d_result, 64'h4008000000000000);
    check("dp_flags", 64'(d_flags), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port Clock  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port InValid  input  1  operands and Op valid this cycle.
REQ-006 SHALL have port InReady  output  1  block accepts operands this cycle.
REQ-007 SHALL have port OpA, OpB  input  W  {sign, exponent, mantissa} operands.
REQ-008 SHALL have port Sub  input  1  1 = OpA-OpB, 0 = OpA+OpB.
REQ-009 SHALL have port OutValid  output  1  Result and flags valid.
REQ-010 SHALL have port OutReady  input  1  downstream accepts Result.
REQ-011 SHALL have port Result  output  W  rounded sum.
REQ-012 SHALL have port Flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 Transfer in SHALL occur when InValid & InReady; transfer out when OutValid & OutReady.
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/compare/align, S2 mantissa add/sub, S3 normalise/round/pack; latency exactly 3 cycles with OutReady held high.
REQ-015 Each stage SHALL advance when its successor is empty or advancing; InReady = NOT(S1 full AND S1 stalled); full throughput of one result per cycle.
REQ-016 While OutReady=0, Result/Flags/OutValid SHALL hold stable; results leave in acceptance order; none dropped or duplicated.
REQ-017 Sub SHALL be applied by inverting OpB sign in S1.
REQ-018 S1 SHALL swap operands so the larger magnitude (exponent, then mantissa) is A; ties choose OpA; result sign = sign of A except exact cancellation.
REQ-019 Alignment SHALL right-shift B's significand (hidden bit included) by exponent difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 SHALL yield significand 0, sticky = OR of B's significand.
REQ-020 S2 SHALL compute MAN_W+5-bit add or subtract of aligned significands; no negative result possible after REQ-018 swap.
REQ-021 S3 SHALL normalise: carry-out -> right shift 1, exponent+1; else left shift by leading-zero count (priority encoder), exponent decreased accordingly.
REQ-022 Rounding SHALL be round-to-nearest-even; mantissa overflow from rounding SHALL increment exponent.
REQ-023 Exact cancellation SHALL return +0 (both operands zero with equal sign returns that signed zero).
REQ-024 Subnormal inputs SHALL be flushed to signed zero; results below min normal SHALL flush to signed zero with underflow=1, inexact=1.
REQ-025 Exponent reaching all-ones after rounding SHALL give signed infinity, overflow=1, inexact=1.
REQ-026 Specials: NaN operand -> canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0); inf + opposite inf -> canonical NaN, invalid=1; inf + finite -> that inf, no flags.
REQ-027 inexact SHALL be set when any of guard/round/sticky is non-zero before rounding.

Reset
REQ-028 Reset SHALL clear all stage valid bits; OutValid=0, InReady=1 in the cycle after Reset deasserts.
REQ-029 Reset SHALL force Result=0, Flags=0; datapath registers other than valids need not reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; none emerge afterward.
REQ-031 InValid during Reset SHALL be ignored.

Structure
REQ-032 Shared package floatingpoint SHALL gain parametrised unpacked-operand struct, flag struct, and class enum {ZERO, NORMAL, INF, NAN}.
REQ-033 Canonical NaN and flag bit positions SHALL be package constants.
REQ-034 Leading-zero count SHALL be a sub-module fp_lzc, parametrised on width, returning count and all-zero indication.
REQ-035 Default parameters SHALL be bit-compatible with single-precision encoding.

Verification
REQ-036 0x3F800000 + 0x3F800000, Sub=0 -> 0x40000000, Flags=0, OutValid exactly 3 cycles after acceptance.
REQ-037 0x3F800000 - 0x3F800000, Sub=1 -> 0x00000000, Flags=0.
REQ-038 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, inexact=1; 0x3F800001 + 0x33800000 -> 0x3F800002, inexact=1.
REQ-039 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1, inexact=1; 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1.
REQ-040 Back-to-back 8 operations, OutReady low cycles 4-8 -> InReady low once 3 held, results held stable, all 8 correct in order; Reset during stream -> OutValid=0 next cycle, no stale outputs.
REQ-041 EXP_W=11, MAN_W=52 build: 1.0 + 2.0 (0x3FF0000000000000 + 0x4000000000000000) -> 0x4008000000000000.
